// File: rtl/morse_key_sequencer.sv
// morse_key_sequencer: keys one encoded Morse letter per valid/ready handshake.
// Marks and gaps are timed in units of max(unit_div,1) clock cycles by an
// internal prescaler. unit_div is sampled when a letter is accepted.
// Optional feature macro: MORSE_WORD_GAP_EN. When it is defined, in_len = 0
// requests a 4-unit word space (WGAP). When it is undefined, in_len = 0 pulses
// done one cycle after accept and produces no key activity.
module morse_key_sequencer #(
  parameter int WID    = 5,
  parameter int MAXLEN = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WID-1:0]    unit_div,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MAXLEN-1:0] in_code,
  input  logic [2:0]        in_len,
  output logic              key_out,
  output logic              busy,
  output logic              done,
  output logic              unit_tick
);

  typedef enum logic [2:0] {
    IDLE,
    MARK,
    SPACE,
    LGAP
`ifdef MORSE_WORD_GAP_EN
    , WGAP
`endif
  } state_t;

  localparam logic [WID-1:0] ONE     = {{(WID-1){1'b0}}, 1'b1};
  localparam logic [2:0]     MAXLEN3 = 3'(MAXLEN);

  state_t            state_reg;
  logic [WID-1:0]    pc_reg;
  logic [WID-1:0]    d_reg;
  logic [1:0]        units_reg;
  logic [2:0]        idx_reg;
  logic [2:0]        len_reg;
  logic [MAXLEN-1:0] code_reg;
  logic              zero_reg;
  logic              key_reg;
  logic              ready_reg;

  logic [WID-1:0]    d_m1;
  logic              unit_end;
  logic [1:0]        mark_last;
  logic [2:0]        len_clamped;
  logic [WID-1:0]    d_accept;
  logic              more_elems;

  // Per-cycle decode of the current unit, element and incoming letter.
  always_comb begin
    d_m1        = d_reg - ONE;
    unit_end    = (state_reg != IDLE) && (pc_reg == d_m1);
    mark_last   = code_reg[idx_reg] ? 2'd2 : 2'd0;
    len_clamped = (in_len > MAXLEN3) ? MAXLEN3 : in_len;
    d_accept    = (unit_div == '0) ? ONE : unit_div;
    more_elems  = ((idx_reg + 3'd1) < len_reg);
  end

  assign in_ready  = ready_reg;
  assign key_out   = key_reg;
  assign busy      = (state_reg != IDLE);
  assign unit_tick = unit_end;
`ifdef MORSE_WORD_GAP_EN
  assign done = ((state_reg == LGAP) && (zero_reg || (unit_end && (units_reg == 2'd2))))
             || ((state_reg == WGAP) && unit_end && (units_reg == 2'd3));
`else
  assign done = (state_reg == LGAP) && (zero_reg || (unit_end && (units_reg == 2'd2)));
`endif

  // Sequencer FSM: handles acceptance, the prescaler, the unit and element
  // counters, and the registered key and ready outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      pc_reg    <= '0;
      d_reg     <= '0;
      units_reg <= '0;
      idx_reg   <= '0;
      len_reg   <= '0;
      code_reg  <= '0;
      zero_reg  <= 1'b0;
      key_reg   <= 1'b0;
      ready_reg <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid && ready_reg) begin
            code_reg  <= in_code;
            len_reg   <= len_clamped;
            d_reg     <= d_accept;
            pc_reg    <= '0;
            units_reg <= '0;
            idx_reg   <= '0;
            ready_reg <= 1'b0;
            if (len_clamped == 3'd0) begin
`ifdef MORSE_WORD_GAP_EN
              state_reg <= WGAP;
`else
              state_reg <= LGAP;
              zero_reg  <= 1'b1;
`endif
            end else begin
              state_reg <= MARK;
              key_reg   <= 1'b1;
            end
          end
        end
        MARK: begin
          if (unit_end) begin
            pc_reg <= '0;
            if (units_reg == mark_last) begin
              units_reg <= '0;
              key_reg   <= 1'b0;
              state_reg <= more_elems ? SPACE : LGAP;
            end else begin
              units_reg <= units_reg + 2'd1;
            end
          end else begin
            pc_reg <= pc_reg + ONE;
          end
        end
        SPACE: begin
          if (unit_end) begin
            pc_reg    <= '0;
            units_reg <= '0;
            idx_reg   <= idx_reg + 3'd1;
            key_reg   <= 1'b1;
            state_reg <= MARK;
          end else begin
            pc_reg <= pc_reg + ONE;
          end
        end
        LGAP: begin
          if (zero_reg || (unit_end && (units_reg == 2'd2))) begin
            pc_reg    <= '0;
            units_reg <= '0;
            zero_reg  <= 1'b0;
            ready_reg <= 1'b1;
            state_reg <= IDLE;
          end else if (unit_end) begin
            pc_reg    <= '0;
            units_reg <= units_reg + 2'd1;
          end else begin
            pc_reg <= pc_reg + ONE;
          end
        end
`ifdef MORSE_WORD_GAP_EN
        WGAP: begin
          if (unit_end && (units_reg == 2'd3)) begin
            pc_reg    <= '0;
            units_reg <= '0;
            ready_reg <= 1'b1;
            state_reg <= IDLE;
          end else if (unit_end) begin
            pc_reg    <= '0;
            units_reg <= units_reg + 2'd1;
          end else begin
            pc_reg <= pc_reg + ONE;
          end
        end
`endif
        default: begin
          state_reg <= IDLE;
          key_reg   <= 1'b0;
          ready_reg <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_morse_key_sequencer.sv
// Testbench for morse_key_sequencer: table of letters with hand-computed
// timing totals, plus reset-abort and backpressure sequences.
module tb_morse_key_sequencer;

  logic       clk;
  logic       reset;
  logic [4:0] unit_div;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] in_code;
  logic [2:0] in_len;
  logic       key_out;
  logic       busy;
  logic       done;
  logic       unit_tick;

  int n_cmp;
  int n_bad;

  morse_key_sequencer #(.WID(5), .MAXLEN(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .unit_div  (unit_div),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_code   (in_code),
    .in_len    (in_len),
    .key_out   (key_out),
    .busy      (busy),
    .done      (done),
    .unit_tick (unit_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] ud;
    logic [4:0] ud_after;
    logic [4:0] code;
    logic [2:0] len;
    int         cyc;
    int         high;
    int         ticks;
    int         marks;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Sends one letter and measures it; called at posedge+1 with the DUT idle.
  task automatic run_letter(input vec_t v, output int cyc, output int high,
                            output int ticks, output int marks,
                            output int dones, output int done_at,
                            output int timeout);
    logic prev_key;
    cyc = 0; high = 0; ticks = 0; marks = 0; dones = 0; done_at = 0; timeout = 0;
    unit_div = v.ud;
    in_code  = v.code;
    in_len   = v.len;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    unit_div = v.ud_after;
    prev_key = 1'b0;
    while (busy && (cyc < 500)) begin
      cyc++;
      if (key_out) high++;
      if (unit_tick) ticks++;
      if (key_out && !prev_key) marks++;
      if (done) begin
        dones++;
        done_at = cyc;
      end
      prev_key = key_out;
      @(posedge clk); #1;
    end
    if (cyc >= 500) timeout = 1;
  endtask

  initial begin
    int cyc, high, ticks, marks, dones, done_at, timeout, rdy_viol;
    n_cmp = 0;
    n_bad = 0;
    reset    = 1'b0;
    unit_div = '0;
    in_valid = 1'b0;
    in_code  = '0;
    in_len   = '0;

    //            ud     ud_after code      len   cyc high ticks marks
    vecs[0] = '{5'd5, 5'd5, 5'b00010, 3'd2, 40, 20,  8, 2}; // A
    vecs[1] = '{5'd0, 5'd0, 5'b00000, 3'd1,  4,  1,  4, 1}; // E, D=1
    vecs[2] = '{5'd3, 5'd3, 5'b00001, 3'd1, 18,  9,  6, 1}; // T
    vecs[3] = '{5'd2, 5'd7, 5'b00000, 3'd3, 16,  6,  8, 3}; // S, unit_div changes
    vecs[4] = '{5'd1, 5'd1, 5'b11111, 3'd7, 22, 15, 22, 5}; // clamp to 5 dashes
`ifdef MORSE_WORD_GAP_EN
    vecs[5] = '{5'd3, 5'd3, 5'b00000, 3'd0, 12,  0,  4, 0}; // word space
`else
    vecs[5] = '{5'd3, 5'd3, 5'b00000, 3'd0,  1,  0,  0, 0}; // empty letter
`endif
    vecs[6] = '{5'd2, 5'd2, 5'b01011, 3'd4, 32, 20, 16, 4}; // Q
    vecs[7] = '{5'd1, 5'd1, 5'b00000, 3'd5, 12,  5, 12, 5}; // "5"

    #23;
    check("reset_key", int'(key_out), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_ready", int'(in_ready), 1);
    check("reset_tick", int'(unit_tick), 0);
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      check($sformatf("v%0d_ready_before", i), int'(in_ready), 1);
      run_letter(vecs[i], cyc, high, ticks, marks, dones, done_at, timeout);
      $display("letter %0d: ud=%0d len=%0d code=%b cycles=%0d high=%0d ticks=%0d marks=%0d done_at=%0d",
               i, vecs[i].ud, vecs[i].len, vecs[i].code, cyc, high, ticks, marks, done_at);
      check($sformatf("v%0d_timeout", i), timeout, 0);
      check($sformatf("v%0d_cycles", i), cyc, vecs[i].cyc);
      check($sformatf("v%0d_high", i), high, vecs[i].high);
      check($sformatf("v%0d_ticks", i), ticks, vecs[i].ticks);
      check($sformatf("v%0d_marks", i), marks, vecs[i].marks);
      check($sformatf("v%0d_dones", i), dones, 1);
      check($sformatf("v%0d_done_at", i), done_at, vecs[i].cyc);
      check($sformatf("v%0d_ready_after", i), int'(in_ready), 1);
      check($sformatf("v%0d_key_after", i), int'(key_out), 0);
    end

    // Backpressure: second letter held valid during busy waits until after done.
    unit_div = 5'd1;
    in_code  = 5'b00000;
    in_len   = 3'd1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_code  = 5'b00001;
    cyc = 0;
    rdy_viol = 0;
    while (busy && (cyc < 100)) begin
      cyc++;
      if (in_ready) rdy_viol++;
      @(posedge clk); #1;
    end
    $display("backpressure first letter: cycles=%0d ready_while_busy=%0d", cyc, rdy_viol);
    check("bp_first_cycles", cyc, 4);
    check("bp_ready_while_busy", rdy_viol, 0);
    check("bp_gap_busy", int'(busy), 0);
    check("bp_gap_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_second_busy", int'(busy), 1);
    check("bp_second_key", int'(key_out), 1);
    cyc = 0;
    high = 0;
    while (busy && (cyc < 100)) begin
      cyc++;
      if (key_out) high++;
      @(posedge clk); #1;
    end
    $display("backpressure second letter: cycles=%0d high=%0d", cyc, high);
    check("bp_second_cycles", cyc, 6);
    check("bp_second_high", high, 3);

    // Reset mid-letter: A at unit_div 5, abort during its dash.
    unit_div = 5'd5;
    in_code  = 5'b00010;
    in_len   = 3'd2;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
    end
    check("abort_key_before", int'(key_out), 1);
    reset = 1'b0;
    #1;
    check("abort_key", int'(key_out), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_ready", int'(in_ready), 1);
    check("abort_done", int'(done), 0);
    #100;
    reset = 1'b1;
    @(posedge clk); #1;
    dones = 0;
    cyc = 0;
    repeat (60) begin
      if (done) dones++;
      if (busy) cyc++;
      @(posedge clk); #1;
    end
    $display("after abort: done pulses=%0d busy cycles=%0d", dones, cyc);
    check("abort_no_done", dones, 0);
    check("abort_no_busy", cyc, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
